// File: rtl/rv_dm_uart_tx.sv
// Data-memory-bus console transmitter: TX FIFO fed by stores, drained as 8N1 UART frames.
// Also exposes STATUS and BAUD registers for loads.
module rv_dm_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_store_done_o,
  output logic        dm_load_done_o,
  output logic        dm_ready_o,
  output logic        uart_txd_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [15:0]       baud, baud_wr, div_lat, timer;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              hit, accept_st, accept_ld, push, push_ok, pop;
  logic              full, empty, bit_end;
  logic [1:0]        reg_sel;
  logic [31:0]       rdata;
  logic              unused_ok;

  // A divisor below 2 cannot produce a usable bit period.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

  assign hit       = (dm_addr_i[31:4] == BASE_ADDR[31:4]);
  assign accept_st = dm_store_i & dm_ready_o & hit;
  assign accept_ld = dm_load_i & dm_ready_o & hit;
  assign reg_sel   = dm_addr_i[3:2];
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign push      = accept_st & (reg_sel == 2'd0) & dm_data_select_i[0];
  assign push_ok   = push & (~full | pop);
  assign bit_end   = (timer == 16'd0);
  assign unused_ok = ^{dm_addr_i[1:0], dm_data_s_i[31:16], dm_data_select_i[3:2]};

  always_comb begin
    baud_wr = baud;
    if (dm_data_select_i[0]) baud_wr[7:0]  = dm_data_s_i[7:0];
    if (dm_data_select_i[1]) baud_wr[15:8] = dm_data_s_i[15:8];
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd1: begin
        rdata[0]    = (state != IDLE);
        rdata[1]    = full;
        rdata[2]    = empty;
        rdata[3]    = overflow;
        rdata[15:8] = 8'(level);
      end
      2'd2:    rdata[15:0] = baud;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      overflow        <= 1'b0;
      baud            <= DEFAULT_DIV;
      timer           <= '0;
      bit_cnt         <= '0;
      uart_txd_o      <= 1'b1;
      dm_ready_o      <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_load_done_o  <= 1'b0;
      dm_data_l_o     <= '0;
    end else begin
      state           <= state_d;
      dm_ready_o      <= 1'b1;
      dm_store_done_o <= accept_st;
      dm_load_done_o  <= accept_ld;
      dm_data_l_o     <= accept_ld ? rdata : 32'd0;

      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push_ok) - LVL_W'(pop);

      if (push && full && !pop)
        overflow <= 1'b0 | 1'b1;
      else if (accept_st && reg_sel == 2'd1 && dm_data_select_i[0] && dm_data_s_i[3])
        overflow <= 1'b0;

      if (accept_st && reg_sel == 2'd2) baud <= clamp_div(baud_wr);

      // A pop starts a frame, so the bit timer reloads from the live BAUD value here.
      if (pop) begin
        timer   <= baud - 16'd1;
        bit_cnt <= 3'd0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          timer <= div_lat - 16'd1;
          if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
        end else begin
          timer <= timer - 16'd1;
        end
      end

      case (state)
        START:   uart_txd_o <= 1'b0;
        DATA:    uart_txd_o <= shreg[0];
        default: uart_txd_o <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= dm_data_s_i[7:0];
    if (pop) begin
      shreg   <= fifo_mem[rd_ptr];
      div_lat <= baud;
    end else if (state == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_rv_dm_uart_tx.sv
// Scoreboard bench for rv_dm_uart_tx: a cycle-counting reference model predicts bus
// responses and UART frames; independent monitors compare them against the DUT.
module tb_rv_dm_uart_tx;
  localparam logic [31:0] BASE    = 32'h0010_0000;
  localparam int          DEPTH   = 16;
  localparam int          DEF_DIV = 868;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i, dm_data_s_i, dm_data_l_o;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i, dm_load_i;
  logic        dm_store_done_o, dm_load_done_o, dm_ready_o, uart_txd_o;

  rv_dm_uart_tx #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'(DEF_DIV))
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i), .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
    .dm_data_l_o(dm_data_l_o), .dm_store_done_o(dm_store_done_o),
    .dm_load_done_o(dm_load_done_o), .dm_ready_o(dm_ready_o), .uart_txd_o(uart_txd_o)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct { int k; logic [31:0] val; } ld_t;
  typedef struct { logic [7:0] b; int start; int div; } fr_t;

  ld_t        load_q[$];
  int         store_q[$];
  fr_t        frame_q[$];
  logic [7:0] mq[$];
  int         next_pop = 0;
  bit         m_ovf = 1'b0;
  int         m_baud = DEF_DIV;
  bit         m_ready = 1'b0;
  bit         mon_busy = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (edge %0d)", name, edge_no);
  endtask

  // One clock: drive the request, advance the reference model for that edge, wait for the next negedge.
  task automatic step(input bit rst, input bit st, input bit ld, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sel);
    int          k;
    int          n_before;
    bit          acc, pop, busy;
    logic [31:0] rd;
    logic [15:0] nb;
    k = edge_no + 1;
    rst_i = rst; dm_store_i = st; dm_load_i = ld;
    dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = sel;
    if (rst) begin
      mq.delete(); frame_q.delete();
      next_pop = 0; m_ovf = 1'b0; m_baud = DEF_DIV; m_ready = 1'b0;
    end else begin
      busy = (k - 1) < next_pop;
      acc  = m_ready && (st || ld) && (a[31:4] == BASE[31:4]);
      if (acc && ld) begin
        rd = 32'd0;
        if (a[3:2] == 2'd1) begin
          rd[0] = busy; rd[1] = (mq.size() == DEPTH); rd[2] = (mq.size() == 0);
          rd[3] = m_ovf; rd[15:8] = 8'(mq.size());
        end else if (a[3:2] == 2'd2) begin
          rd[15:0] = 16'(m_baud);
        end
        load_q.push_back('{k, rd});
      end
      if (acc && st) store_q.push_back(k);
      n_before = mq.size();
      pop = (n_before > 0) && (k >= next_pop);
      if (pop) begin
        frame_q.push_back('{mq.pop_front(), k + 1, m_baud});
        next_pop = k + 10 * m_baud;
      end
      if (acc && st) begin
        case (a[3:2])
          2'd0: if (sel[0]) begin
            if (n_before == DEPTH && !pop) m_ovf = 1'b1;
            else mq.push_back(d[7:0]);
          end
          2'd1: if (sel[0] && d[3]) m_ovf = 1'b0;
          2'd2: begin
            nb = 16'(m_baud);
            if (sel[0]) nb[7:0]  = d[7:0];
            if (sel[1]) nb[15:8] = d[15:8];
            m_baud = (nb < 16'd2) ? 2 : int'(nb);
          end
          default: ;
        endcase
      end
      m_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    step(1'b0, 1'b1, 1'b0, a, d, sel);
  endtask
  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b1, a, 32'd0, 4'hF);
  endtask

  task automatic drain();
    int guard = 0;
    while ((frame_q.size() > 0 || mq.size() > 0 || mon_busy || edge_no < next_pop + 2)
           && guard < 40000) begin
      idle(1);
      guard++;
    end
    if (guard >= 40000) fail("drain_timeout");
  endtask

  // Bus response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i !== 1'b1) begin
        while (store_q.size() > 0 && store_q[0] < edge_no) begin
          fail("store_done_missing");
          void'(store_q.pop_front());
        end
        while (load_q.size() > 0 && load_q[0].k < edge_no) begin
          fail("load_done_missing");
          void'(load_q.pop_front());
        end
        if (dm_store_done_o === 1'b1) begin
          if (store_q.size() == 0) fail("store_done_unexpected");
          else check("store_done_edge", edge_no, store_q.pop_front());
        end
        if (dm_load_done_o === 1'b1) begin
          if (load_q.size() == 0) fail("load_done_unexpected");
          else begin
            ld_t e;
            e = load_q.pop_front();
            check("load_done_edge", edge_no, e.k);
            check("load_data", dm_data_l_o, e.val);
          end
        end
      end
    end
  end

  // Serial line monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i !== 1'b1 && uart_txd_o === 1'b0) begin
        mon_busy = 1'b1;
        if (frame_q.size() == 0) begin
          fail("frame_unexpected");
          for (int j = 0; j < 20000 && uart_txd_o !== 1'b1; j++) @(negedge clk);
        end else begin
          fr_t        e;
          int         glitch, bi;
          bit         aborted;
          logic [7:0] got;
          logic       expb;
          e = frame_q.pop_front();
          check("frame_start", edge_no, e.start);
          glitch = 0; aborted = 1'b0; got = 8'd0;
          for (int i = 0; i < 10 * e.div; i++) begin
            if (i > 0) @(negedge clk);
            if (rst_i === 1'b1) begin
              aborted = 1'b1;
              break;
            end
            bi   = i / e.div;
            expb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : e.b[bi-1];
            if (uart_txd_o !== expb) glitch++;
            if (bi >= 1 && bi <= 8 && (i % e.div) == 0) got[bi-1] = uart_txd_o;
          end
          if (!aborted) begin
            check("frame_data", got, e.b);
            check("frame_shape", glitch, 0);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    int          e_st;
    logic [31:0] a, d;
    rst_i = 1'b1; dm_store_i = 1'b0; dm_load_i = 1'b0;
    dm_addr_i = 32'd0; dm_data_s_i = 32'd0; dm_data_select_i = 4'd0;
    @(negedge clk);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("rst_data_l", dm_data_l_o, 32'd0);
    check("rst_store_done", dm_store_done_o, 1'b0);
    check("rst_load_done", dm_load_done_o, 1'b0);
    check("rst_ready", dm_ready_o, 1'b0);
    check("rst_txd", uart_txd_o, 1'b1);
    idle(1);
    check("ready_after_rst", dm_ready_o, 1'b1);
    rd(BASE + 32'h4);
    idle(2);

    // single byte at divisor 4, polling STATUS around the end of the frame
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    wr(BASE, 32'h41, 4'b0001);
    idle(5);
    rd(BASE + 32'h4);
    idle(30);
    repeat (8) rd(BASE + 32'h4);
    drain();

    // three contiguous frames at divisor 2
    wr(BASE + 32'h8, 32'd2, 4'b0011);
    wr(BASE, 32'h55, 4'b0001);
    wr(BASE, 32'hAA, 4'b0001);
    wr(BASE, 32'h0F, 4'b0001);
    rd(BASE + 32'h4);
    drain();

    // overflow at divisor 100
    wr(BASE + 32'h8, 32'd100, 4'b0011);
    for (int i = 0; i < DEPTH + 2; i++) wr(BASE, 32'(8'h30 + i), 4'b0001);
    rd(BASE + 32'h4);
    wr(BASE + 32'h4, 32'h8, 4'b0001);
    rd(BASE + 32'h4);
    drain();

    // decode: out-of-window requests ignored, BAUD clamp, reserved register
    wr(BASE + 32'h10, 32'h66, 4'hF);
    rd(BASE + 32'h10);
    wr(32'h0, 32'h77, 4'hF);
    rd(32'h0);
    idle(30);
    wr(BASE + 32'h8, 32'd1, 4'b0011);
    rd(BASE + 32'h8);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'hC);
    rd(BASE);
    drain();

    // randomized traffic with small divisors
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      d = $urandom;
      if (a[3:2] == 2'd2) d = 32'($urandom_range(0, 6));
      if (r < 4) wr(a, d, 4'($urandom_range(0, 15)));
      else if (r < 7) rd(a);
      else idle(1);
    end
    drain();

    // reset during data bit 3 of a frame
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    wr(BASE, 32'hA5, 4'b0001);
    e_st = edge_no;
    idle(18);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("midrst_txd", uart_txd_o, 1'b1);
    check("midrst_edge", edge_no, e_st + 19);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    idle(1);
    rd(BASE + 32'h4);
    idle(100);
    drain();

    check("store_q_left", store_q.size(), 0);
    check("load_q_left", load_q.size(), 0);
    check("frame_q_left", frame_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
